filter_seq_ctrl: RTL
====================

// Module: filter_seq_ctrl
// PURPOSE
// - Sequences one memory-to-memory filter job: reads len samples from src, streams them through the filter core, writes len results to dest.
// - Sits between top_level's begin_filter/src/len/dest command, the single-port sample RAM and the filter core.
// - Arbitrates the one RAM port between sample reads and result writes, buffering results in an internal FIFO.
// PARAMETERS
// - AW        8   address width (src, dest, mem_addr); addresses wrap modulo 2**AW
// - DW        8   sample/result data width
// - FIFO_DEPTH 4  result FIFO entries; power of two, >=2
// PORTS
// - clk            in   1   clock; all logic rising-edge
// - rst            in   1   synchronous, active-high reset
// - begin_filter   in   1   1-cycle start pulse; src/len/dest sampled in same cycle
// - src            in   AW  first sample address
// - len            in   AW  sample count (0..2**AW-1)
// - dest           in   AW  first result address
// - busy           out  1   job in progress
// - done           out  1   1-cycle pulse, last result written
// - mem_addr       out  AW  RAM address
// - mem_re         out  1   RAM read strobe; mem_rdata valid next cycle
// - mem_we         out  1   RAM write strobe
// - mem_wdata      out  DW  RAM write data
// - mem_rdata      in   DW  RAM read data
// - filt_in_valid  out  1   sample to filter core this cycle
// - filt_in_data   out  DW  sample (= mem_rdata)
// - filt_out_valid in   1   result from filter core (one per sample, any fixed latency)
// - filt_out_data  in   DW  result
// BEHAVIOUR
// - Reset: busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, filt_in_valid=0; FIFO empty, counters 0, state IDLE.
// - Reset mid-job aborts immediately: no further RAM strobes, FIFO flushed, no done.
// - States: IDLE -> RUN on begin_filter with len!=0. IDLE -> FIN on len==0. RUN -> FIN when wr_cnt==len. FIN -> IDLE after one cycle; done=1 in FIN.
// - busy=1 in RUN and FIN, i.e. from the cycle after begin_filter through the done cycle.
// - RUN per-cycle arbitration, at most one RAM access per cycle:
//   - If the FIFO is non-empty, write wins: mem_we=1, mem_addr=dest+wr_cnt, mem_wdata=FIFO head; pop; wr_cnt++.
//   - Else, if rd_cnt<len and credit>0, read: mem_re=1, mem_addr=src+rd_cnt; rd_cnt++.
//   - Else idle: no strobes.
// - Credit: FIFO_DEPTH - (fifo_count + in_flight). in_flight = reads issued whose result has not yet returned via filt_out_valid. Guarantees no FIFO overflow.
// - filt_in_valid is mem_re delayed one cycle; filt_in_data = mem_rdata, combinational.
// - filt_out_valid pushes filt_out_data into the FIFO and decrements in_flight. It is ignored in IDLE.
// - Push and pop in the same cycle are legal; count is unchanged.
// - Address arithmetic is AW bits and wraps: src=250, len=10 reads 250..255, 0..3. Same for dest.
// - Results are written in sample order. Any overlap of src and dest is the caller's responsibility.
// - begin_filter while busy: see CONFIGURATION.
// - Assertions (bench): never mem_re&&mem_we; FIFO never pushed when full.
// CONFIGURATION
// - Macro FILT_SEQ_CMD_QUEUE_EN.
// - Defined: a 1-deep command register captures src/len/dest on begin_filter while busy, one pending max.
//   - Further begin_filter while a command is pending is dropped.
//   - The pending job starts in the cycle after done, i.e. FIN -> RUN directly; busy stays 1 across jobs.
//   - rst clears the pending command.
// - Undefined: begin_filter while busy is ignored; the register is not built.
// TESTING
// - rst; begin_filter src=0 len=50 dest=100 -> 50 reads at 0..49, 50 writes at 100..149 holding filter results in order; one done pulse; busy then 0.
// - len=0 -> done pulses in the cycle after begin_filter, busy=1 that cycle only, no mem_re/mem_we.
// - src=250 len=10 dest=252 -> read addrs 250..255,0..3; write addrs 252..255,0..5.
// - Filter core stub with 8-cycle latency, FIFO_DEPTH=4 -> in_flight+fifo_count never exceeds 4, no overflow, all 20 results written.
// - rst asserted for one cycle mid-job -> next cycle busy=0, no strobes, done never pulses; a new job afterwards completes correctly.
// - Second begin_filter during a job -> with FILT_SEQ_CMD_QUEUE_EN: second job runs back-to-back, two done pulses; without: ignored, one done.

Source files
------------

// File: rtl/filter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : filter_seq_ctrl_if
//  Purpose  : Bundles the job command, sample-RAM port and filter-core stream
//             signals of filter_seq_ctrl.
//             master : the sequencer (drives RAM strobes and filter input)
//             slave  : the environment (command source, RAM, filter core)
//  Signals  : begin_filter/src/len/dest   job command
//             busy/done                   job status
//             mem_addr/mem_re/mem_we/mem_wdata/mem_rdata   single-port RAM
//             filt_in_valid/filt_in_data                   samples to core
//             filt_out_valid/filt_out_data                 results from core
//  Revision : 1.0  initial release
// ============================================================================
interface filter_seq_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          begin_filter;
    logic [AW-1:0] src;
    logic [AW-1:0] len;
    logic [AW-1:0] dest;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          filt_in_valid;
    logic [DW-1:0] filt_in_data;
    logic          filt_out_valid;
    logic [DW-1:0] filt_out_data;

    modport master (
        input  begin_filter, src, len, dest, mem_rdata, filt_out_valid, filt_out_data,
        output busy, done, mem_addr, mem_re, mem_we, mem_wdata, filt_in_valid, filt_in_data
    );

    modport slave (
        output begin_filter, src, len, dest, mem_rdata, filt_out_valid, filt_out_data,
        input  busy, done, mem_addr, mem_re, mem_we, mem_wdata, filt_in_valid, filt_in_data
    );
endinterface
`default_nettype wire

// File: rtl/filter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : filter_seq_ctrl
//  Purpose  : Sequences one memory-to-memory filter job: reads len samples
//             from src, streams them through the filter core and writes len
//             results to dest, sharing one RAM port between reads and writes.
//             Results are buffered in a FIFO_DEPTH-entry FIFO; reads are only
//             issued while credit remains, so the FIFO can never overflow.
//  Ports    : clk, rst (sync, active-high)
//             bus : filter_seq_ctrl_if.master (command, RAM, filter stream)
//  Options  : FILT_SEQ_CMD_QUEUE_EN - when defined, one begin_filter arriving
//             while busy is held and started directly after the current done.
//  Revision : 1.0  initial release
// ============================================================================
module filter_seq_ctrl #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    filter_seq_ctrl_if.master    bus
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_src, r_len, r_dest;
    logic [AW-1:0] r_rd_cnt, r_wr_cnt;
    logic [CW-1:0] r_infl;          // reads issued, result not yet returned
    logic [CW-1:0] r_cnt;           // FIFO occupancy
    logic [PW-1:0] r_wptr, r_rptr;
    logic [DW-1:0] r_fifo [FIFO_DEPTH];
    logic          r_re_d;

    logic          w_launch;
    logic [AW-1:0] w_l_src, w_l_len, w_l_dest;
    logic          w_run, w_re, w_we, w_push;
    logic [CW-1:0] w_occ;

`ifdef FILT_SEQ_CMD_QUEUE_EN
    logic          r_pend_vld;
    logic [AW-1:0] r_pend_src, r_pend_len, r_pend_dest;
    logic          w_capture;
`endif

    // ---------------- next state / job launch ----------------
    always_comb begin
        w_launch    = 1'b0;
        w_l_src     = bus.src;
        w_l_len     = bus.len;
        w_l_dest    = bus.dest;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.begin_filter) w_launch = 1'b1;
            RUN:  if (r_wr_cnt == r_len) w_state_nxt = FIN;
            FIN: begin
                w_state_nxt = IDLE;
`ifdef FILT_SEQ_CMD_QUEUE_EN
                // A held command runs next; a command arriving in the done
                // cycle with nothing held is launched directly.
                if (r_pend_vld) begin
                    w_launch = 1'b1;
                    w_l_src  = r_pend_src;
                    w_l_len  = r_pend_len;
                    w_l_dest = r_pend_dest;
                end else if (bus.begin_filter) begin
                    w_launch = 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_launch) w_state_nxt = (w_l_len != '0) ? RUN : FIN;
    end

`ifdef FILT_SEQ_CMD_QUEUE_EN
    // In FIN the held command is being consumed, so its slot is free again.
    assign w_capture = bus.begin_filter &&
                       (((r_state == RUN) && !r_pend_vld) || ((r_state == FIN) && r_pend_vld));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_src  <= '0;
            r_pend_len  <= '0;
            r_pend_dest <= '0;
        end else if (w_capture) begin
            r_pend_vld  <= 1'b1;
            r_pend_src  <= bus.src;
            r_pend_len  <= bus.len;
            r_pend_dest <= bus.dest;
        end else if (r_state == FIN) begin
            r_pend_vld  <= 1'b0;
        end
    end
`endif

    // ---------------- RAM port arbitration ----------------
    assign w_occ  = r_cnt + r_infl;
    assign w_run  = (r_state == RUN);
    assign w_we   = w_run && (r_cnt != '0);                    // draining results wins
    assign w_re   = w_run && (r_cnt == '0) && (r_rd_cnt != r_len) && (w_occ < c_DEPTH);
    assign w_push = bus.filt_out_valid && (r_state != IDLE);

    assign bus.busy          = (r_state != IDLE);
    assign bus.done          = (r_state == FIN);
    assign bus.mem_re        = w_re;
    assign bus.mem_we        = w_we;
    assign bus.mem_addr      = w_we ? (r_dest + r_wr_cnt) : (w_re ? (r_src + r_rd_cnt) : '0);
    assign bus.mem_wdata     = w_we ? r_fifo[r_rptr] : '0;
    assign bus.filt_in_valid = r_re_d;
    assign bus.filt_in_data  = bus.mem_rdata;

    // ---------------- sequential state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_src    <= '0;
            r_len    <= '0;
            r_dest   <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_infl   <= '0;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_re_d   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_re_d  <= w_re;
            if (w_launch) begin
                r_src    <= w_l_src;
                r_len    <= w_l_len;
                r_dest   <= w_l_dest;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_re) r_rd_cnt <= r_rd_cnt + AW'(1);
                if (w_we) r_wr_cnt <= r_wr_cnt + AW'(1);
            end
            case ({w_re, w_push})
                2'b10:   r_infl <= r_infl + CW'(1);
                2'b01:   r_infl <= r_infl - CW'(1);
                default: r_infl <= r_infl;
            endcase
            case ({w_push, w_we})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_we)   r_rptr <= r_rptr + PW'(1);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.filt_out_data;
    end
endmodule
`default_nettype wire
